// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product in WIDTH cycles,
// unsigned or two's-complement per operation, with a start/busy/done handshake.
module seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   res
);

   localparam int ACC_W = 2 * WIDTH;
   localparam int CW    = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mult_q, mult_d;
   logic               neg_q, neg_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   res_q, res_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ACC_W-1:0]   addend;
   logic [ACC_W-1:0]   acc_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= '0;
         mult_q  <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         mult_q  <= mult_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      mult_d  = mult_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      addend  = mult_q[0] ? (ACC_W'(mcand_q) << cnt_q) : '0;
      acc_sum = acc_q + addend;

      case (state_q)
         RUN: begin
            acc_d  = acc_sum;
            mult_d = mult_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Final iteration: publish the signed-corrected sum directly.
               state_d = DONE;
               cnt_d   = '0;
               res_d   = neg_q ? -acc_sum : acc_sum;
            end
         end
         default: begin
            if (start) begin
               // The magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), still valid unsigned.
               mcand_d = (signed_mode && a[WIDTH-1]) ? -a : a;
               mult_d  = (signed_mode && b[WIDTH-1]) ? -b : b;
               neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign res  = res_q;

endmodule
